// File: rtl/spdif_src_sched.sv
// SPDIF sample scheduler: arbitrates source A (priority) and source B into a small FIFO,
// flushing and muting on every source change. Define SPDIF_SCHED_STATS_EN to build the underrun counter.
module spdif_src_sched #(
  parameter int FIFO_AW   = 2,
  parameter int MUTE_REQS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  src_en_i,
  input  logic [31:0] a_data_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [31:0] b_data_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  input  logic        sample_req_i,
  output logic [31:0] sample_o,
  output logic [1:0]  active_src_o,
  output logic        underrun_o,
  output logic [15:0] underrun_cnt_o
);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    SRC_A_S = 2'd1,
    SRC_B_S = 2'd2,
    FLUSH_S = 2'd3
  } state_t;

  localparam logic [FIFO_AW:0]   DEPTH_C    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ZERO_C = (FIFO_AW+1)'(0);
  localparam logic [FIFO_AW:0]   CNT_ONE_C  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO_C = FIFO_AW'(0);
  localparam logic [FIFO_AW-1:0] PTR_ONE_C  = FIFO_AW'(1);
  localparam logic [7:0]         MUTE_LD_C  = 8'(MUTE_REQS);

  state_t              state_r, state_s, dest_s;
  logic [1:0]          tgt_s, pend_r, pend_s;
  logic [7:0]          mute_r, mute_s;
  logic [31:0]         mem_r [0:(2**FIFO_AW)-1];
  logic [FIFO_AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]    count_r, count_s;
  logic                in_src_s, push_s, pop_s, flush_s, underrun_s;
  logic [31:0]         push_data_s;

  function automatic logic [1:0] src_code(input state_t st);
    case (st)
      SRC_A_S: src_code = 2'b01;
      SRC_B_S: src_code = 2'b10;
      default: src_code = 2'b00;
    endcase
  endfunction

  // Target source: A wins over B.
  always_comb begin
    if (src_en_i[0]) begin
      tgt_s = 2'b01;
    end else if (src_en_i[1]) begin
      tgt_s = 2'b10;
    end else begin
      tgt_s = 2'b00;
    end
  end

  // Destination state once the mute window of the pending source ends.
  always_comb begin
    case (pend_r)
      2'b01:   dest_s = SRC_A_S;
      2'b10:   dest_s = SRC_B_S;
      default: dest_s = IDLE_S;
    endcase
  end

  // Next-state, pending source and mute counter.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    mute_s  = mute_r;
    case (state_r)
      IDLE_S, SRC_A_S, SRC_B_S: begin
        if (tgt_s != src_code(state_r)) begin
          state_s = FLUSH_S;
          pend_s  = tgt_s;
          mute_s  = MUTE_LD_C;
        end else begin
          state_s = state_r;
        end
      end
      FLUSH_S: begin
        if (tgt_s != pend_r) begin
          pend_s = tgt_s;
          mute_s = MUTE_LD_C;
        end else if (sample_req_i && (mute_r != 8'd0)) begin
          mute_s = mute_r - 8'd1;
          if (mute_r == 8'd1) begin
            state_s = dest_s;
          end else begin
            state_s = FLUSH_S;
          end
        end else if (mute_r == 8'd0) begin
          state_s = dest_s;
        end else begin
          state_s = FLUSH_S;
        end
      end
      default: state_s = IDLE_S;
    endcase
  end

  // FIFO control: push on handshake, pop on request, clear when entering FLUSH.
  always_comb begin
    in_src_s    = (state_r == SRC_A_S) || (state_r == SRC_B_S);
    push_s      = (a_valid_i && a_ready_o) || (b_valid_i && b_ready_o);
    push_data_s = a_ready_o ? a_data_i : b_data_i;
    pop_s       = sample_req_i && in_src_s && (count_r != CNT_ZERO_C);
    underrun_s  = sample_req_i && in_src_s && (count_r == CNT_ZERO_C);
    flush_s     = (state_s == FLUSH_S) && (state_r != FLUSH_S);
    if (flush_s) begin
      count_s = CNT_ZERO_C;
    end else if (push_s && !pop_s) begin
      count_s = count_r + CNT_ONE_C;
    end else if (pop_s && !push_s) begin
      count_s = count_r - CNT_ONE_C;
    end else begin
      count_s = count_r;
    end
  end

  // State, pointers and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE_S;
      pend_r   <= 2'b00;
      mute_r   <= 8'd0;
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
      mute_r  <= mute_s;
      count_r <= count_s;
      if (flush_s) begin
        wr_ptr_r <= PTR_ZERO_C;
        rd_ptr_r <= PTR_ZERO_C;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
    end
  end

  // FIFO storage; a push coinciding with a flush is dropped.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Registered outputs; ready looks ahead at next state and next count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_o     <= 32'h0000_0000;
      active_src_o <= 2'b00;
      a_ready_o    <= 1'b0;
      b_ready_o    <= 1'b0;
      underrun_o   <= 1'b0;
    end else begin
      if (sample_req_i) begin
        sample_o <= pop_s ? mem_r[rd_ptr_r] : 32'h0000_0000;
      end
      active_src_o <= src_code(state_s);
      a_ready_o    <= (state_s == SRC_A_S) && (count_s < DEPTH_C);
      b_ready_o    <= (state_s == SRC_B_S) && (count_s < DEPTH_C);
      underrun_o   <= underrun_s;
    end
  end

`ifdef SPDIF_SCHED_STATS_EN
  logic [15:0] urun_cnt_r;

  // Saturating underrun counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      urun_cnt_r <= 16'h0000;
    end else if (underrun_s && (urun_cnt_r != 16'hFFFF)) begin
      urun_cnt_r <= urun_cnt_r + 16'h0001;
    end
  end

  assign underrun_cnt_o = urun_cnt_r;
`else
  assign underrun_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_spdif_src_sched.sv
// Directed bench for spdif_src_sched: mute after switch, FIFO full/ready, underrun, flush, reload, reset.
module tb_spdif_src_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  src_en_i;
  logic [31:0] a_data_i, b_data_i;
  logic        a_valid_i, b_valid_i, sample_req_i;
  logic        a_ready_o, b_ready_o, underrun_o;
  logic [31:0] sample_o;
  logic [1:0]  active_src_o;
  logic [15:0] underrun_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  int a_acc    = 0;

`ifdef SPDIF_SCHED_STATS_EN
  localparam logic [31:0] EXP_URUN = 32'd3;
`else
  localparam logic [31:0] EXP_URUN = 32'd0;
`endif

  spdif_src_sched #(.FIFO_AW(2), .MUTE_REQS(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .src_en_i       (src_en_i),
    .a_data_i       (a_data_i),
    .a_valid_i      (a_valid_i),
    .a_ready_o      (a_ready_o),
    .b_data_i       (b_data_i),
    .b_valid_i      (b_valid_i),
    .b_ready_o      (b_ready_o),
    .sample_req_i   (sample_req_i),
    .sample_o       (sample_o),
    .active_src_o   (active_src_o),
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the source models advance their data on each accepted handshake.
  task automatic tick();
    logic acc_a, acc_b;
    acc_a = a_valid_i && a_ready_o;
    acc_b = b_valid_i && b_ready_o;
    @(posedge clk_i);
    #1;
    sample_req_i = 1'b0;
    if (acc_a) begin
      a_data_i = a_data_i + 32'd1;
      a_acc++;
    end
    if (acc_b) b_data_i = b_data_i + 32'd1;
  endtask

  task automatic req();
    sample_req_i = 1'b1;
    tick();
  endtask

  task automatic mute_seq(input string tag, input logic [1:0] exp_src);
    for (int i = 0; i < 8; i++) begin
      req();
      check({tag, "_zero"}, sample_o, 32'd0);
      if (i < 7) begin
        check({tag, "_act"}, {30'd0, active_src_o}, 32'd0);
        check({tag, "_rdy"}, {30'd0, a_ready_o, b_ready_o}, 32'd0);
      end else begin
        check({tag, "_act_end"}, {30'd0, active_src_o}, {30'd0, exp_src});
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; src_en_i = 2'b00; sample_req_i = 1'b0;
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    a_data_i = 32'd1; b_data_i = 32'hB000_0001;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_sample", sample_o, 32'd0);
    check("rst_act", {30'd0, active_src_o}, 32'd0);
    check("rst_rdy", {30'd0, a_ready_o, b_ready_o}, 32'd0);
    check("rst_urun", {31'd0, underrun_o}, 32'd0);
    check("rst_cnt", {16'd0, underrun_cnt_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Switch to A: 8 muted requests.
    src_en_i = 2'b01; a_valid_i = 1'b1;
    tick();
    check("t1_flush_act", {30'd0, active_src_o}, 32'd0);
    mute_seq("t1", 2'b01);
    check("t1_a_rdy", {31'd0, a_ready_o}, 32'd1);

    // Fill to depth, then one pop admits exactly one more.
    repeat (4) tick();
    check("t2_full_rdy", {31'd0, a_ready_o}, 32'd0);
    check("t2_acc4", a_acc, 32'd4);
    repeat (2) tick();
    check("t2_acc_hold", a_acc, 32'd4);
    req();
    check("t2_s1", sample_o, 32'd1);
    check("t2_rdy_up", {31'd0, a_ready_o}, 32'd1);
    tick();
    check("t2_acc5", a_acc, 32'd5);
    check("t2_rdy_down", {31'd0, a_ready_o}, 32'd0);
    tick();
    check("t2_hold", sample_o, 32'd1);
    req();
    check("t2_s2", sample_o, 32'd2);
    req();
    check("t2_s3", sample_o, 32'd3);
    a_valid_i = 1'b0;

    // Drain, then underruns.
    req(); check("t3_s4", sample_o, 32'd4);
    req(); check("t3_s5", sample_o, 32'd5);
    req(); check("t3_s6", sample_o, 32'd6);
    check("t3_no_urun", {31'd0, underrun_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      req();
      check("t3_urun", {31'd0, underrun_o}, 32'd1);
      check("t3_zero", sample_o, 32'd0);
      tick();
      check("t3_urun_low", {31'd0, underrun_o}, 32'd0);
    end
    check("t3_cnt", {16'd0, underrun_cnt_o}, EXP_URUN);

    // A buffered, 01 -> 11 -> 10.
    a_valid_i = 1'b1;
    tick(); tick();
    check("t4_b_rdy0", {31'd0, b_ready_o}, 32'd0);
    src_en_i = 2'b11;
    tick();
    check("t4_act_a", {30'd0, active_src_o}, 32'd1);
    check("t4_b_rdy1", {31'd0, b_ready_o}, 32'd0);
    src_en_i = 2'b10;
    tick();
    a_valid_i = 1'b0;
    check("t4_flush_act", {30'd0, active_src_o}, 32'd0);
    check("t4_flush_rdy", {30'd0, a_ready_o, b_ready_o}, 32'd0);
    b_valid_i = 1'b1;
    mute_seq("t4", 2'b10);
    check("t4_b_rdy", {31'd0, b_ready_o}, 32'd1);
    tick(); tick();
    req(); check("t4_b1", sample_o, 32'hB000_0001);
    req(); check("t4_b2", sample_o, 32'hB000_0002);

    // Target change in FLUSH reloads the mute counter.
    src_en_i = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
      req();
      check("t5_pre_zero", sample_o, 32'd0);
    end
    src_en_i = 2'b01; a_valid_i = 1'b1;
    tick();
    mute_seq("t5", 2'b01);
    tick();
    req(); check("t5_a11", sample_o, 32'd11);

    // Reset mid-stream in SRC_B, FIFO half full.
    src_en_i = 2'b10; a_valid_i = 1'b0;
    tick();
    mute_seq("t6a", 2'b10);
    tick(); tick();
    req(); check("t6_b6", sample_o, 32'hB000_0006);
    rst_i = 1'b1;
    #1;
    check("t6_rst_sample", sample_o, 32'd0);
    check("t6_rst_act", {30'd0, active_src_o}, 32'd0);
    check("t6_rst_rdy", {30'd0, a_ready_o, b_ready_o}, 32'd0);
    check("t6_rst_urun", {31'd0, underrun_o}, 32'd0);
    check("t6_rst_cnt", {16'd0, underrun_cnt_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick();
    mute_seq("t6b", 2'b10);
    tick();
    req(); check("t6_b9", sample_o, 32'hB000_0009);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
